frame_mem_arbiter: RTL and testbench
====================================

FRAME_MEM_ARBITER -- requirements
Module: frame_mem_arbiter

Interface
REQ-001 SHALL have parameter FRAME_W, default 160, frame width in pixels.
REQ-002 SHALL have parameter FRAME_H, default 120, frame height in pixels.
REQ-003 SHALL have parameter MAX_WAIT, default 4, the longest run of refused processor-request cycles allowed.
REQ-004 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have ports disp_req in 1, disp_addr in 15  display read request and pixel address.
REQ-007 SHALL have ports disp_gnt out 1, disp_rdata out 24, disp_rvalid out 1  display grant, read data and read-data valid.
REQ-008 SHALL have ports proc_req in 1, proc_we in 1, proc_addr in 15, proc_wdata in 24  blur-processor request, write strobe, address and write data.
REQ-009 SHALL have ports proc_gnt out 1, proc_rdata out 24, proc_rvalid out 1  processor grant, read data and read-data valid.
REQ-010 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out 15, mem_wdata out 24, mem_rdata in 24  single-port synchronous RAM, read latency 1.
REQ-011 SHALL have ports owner out 2 (0 idle, 1 display, 2 processor) and oob_err out 1 (sticky).

Function
REQ-012 SHALL combinationally assert at most one of disp_gnt and proc_gnt per cycle; a request is accepted on the clock edge that ends its granted cycle.
REQ-013 SHALL grant display on conflict unless wait_cnt == MAX_WAIT, in which case the processor is granted and display is refused for that cycle.
REQ-014 SHALL grant a lone requester in the same cycle it requests.
REQ-015 SHALL increment wait_cnt (3 bits, saturating at MAX_WAIT) each cycle proc_req=1 and proc_gnt=0, and clear it on proc_gnt=1 or proc_req=0.
REQ-016 SHALL register mem_en, mem_we, mem_addr and mem_wdata from the granted request at the accepting edge (one cycle after grant); when nothing is granted, mem_en=0 and mem_we=0.
REQ-017 SHALL drive mem_we=1 only for a granted processor request with proc_we=1; display requests are read-only.
REQ-018 SHALL assert rvalid to the original read requester exactly 2 cycles after its grant cycle, with rdata equal to mem_rdata in that cycle.
REQ-019 SHALL track read ownership with a 2-stage tag pipeline, so back-to-back grants to alternating requesters return data in grant order with no loss.
REQ-020 SHALL assert no rvalid for writes.
REQ-021 SHALL treat addresses >= FRAME_W*FRAME_H (19200) as out of range: grant normally, hold mem_en=0 and mem_we=0, return rvalid with rdata=0 for reads, and set oob_err.
REQ-022 SHALL implement a state machine with states IDLE, DISP and PROC: the next state is set by the grant issued this cycle (none gives IDLE), and owner reflects the current state.
REQ-023 SHALL hold disp_rdata and proc_rdata at 0 whenever the corresponding rvalid=0.

Reset
REQ-024 SHALL, while rst=1, force state IDLE, wait_cnt=0, tag pipeline empty, oob_err=0, and every output 0, independent of clk.
REQ-025 SHALL discard in-flight reads on reset: no rvalid after rst deasserts for grants issued before reset.
REQ-026 SHALL accept requests in the first cycle after rst deasserts.

Structure
REQ-027 SHALL place FRAME_W, FRAME_H, the derived DEPTH, ADDR_W=15, DATA_W=24 and the owner encoding in shared package frame_mem_pkg.
REQ-028 SHALL implement the read-tag pipeline as one sub-module, rd_tag_pipe (2-deep, valid + owner + oob per stage).

Verification
REQ-029 Processor alone writes 0xABCDEF to addr 100, then reads addr 100 -> proc_gnt in both request cycles; mem_we=1 one cycle after the first grant; proc_rvalid with 0xABCDEF two cycles after the read grant.
REQ-030 disp_req and proc_req both held high for 12 cycles -> display granted 4 cycles, then processor 1 cycle, repeating; processor never refused more than 4 consecutive cycles.
REQ-031 Alternating grants: display reads addr 0, processor reads addr 1, display reads addr 2 on consecutive cycles -> rvalids return in that order, each with the correct RAM contents.
REQ-032 Processor writes to addr 19200, then display reads addr 19200 -> mem_en stays 0, oob_err=1 and stays set, disp_rvalid returns with rdata=0.
REQ-033 rst asserted in the cycle after a display read grant -> outputs go to 0 immediately; no disp_rvalid after release; a new request is granted in the first cycle after release.

Source files
------------

// File: rtl/frame_mem_pkg.sv
// frame_mem_pkg: shared frame geometry, bus widths, owner encoding and read-tag record
package frame_mem_pkg;
  localparam int FRAME_W = 160;
  localparam int FRAME_H = 120;
  localparam int DEPTH = FRAME_W * FRAME_H;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 24;
  typedef enum logic [1:0] {IDLE = 2'd0, DISP = 2'd1, PROC = 2'd2} owner_t;
  typedef struct packed {
    logic valid;
    owner_t owner;
    logic oob;
  } tag_t;
  function automatic logic out_of_range(input logic [ADDR_W-1:0] addr, input int depth);
    return {1'b0, addr} >= (ADDR_W + 1)'(depth);
  endfunction
endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: two-stage read-ownership tags aligned with the one-cycle RAM read latency
module rd_tag_pipe
  import frame_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);
  tag_t stage [2];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stage[0] <= '{valid: 1'b0, owner: IDLE, oob: 1'b0};
      stage[1] <= '{valid: 1'b0, owner: IDLE, oob: 1'b0};
    end else begin
      stage[0] <= tag_in;
      stage[1] <= stage[0];
    end
  assign tag_out = stage[1];
endmodule

// File: rtl/frame_mem_arbiter.sv
// frame_mem_arbiter: display/processor arbiter for a single-port frame RAM with starvation bound
module frame_mem_arbiter #(
  parameter int FRAME_W = frame_mem_pkg::FRAME_W,
  parameter int FRAME_H = frame_mem_pkg::FRAME_H,
  parameter int MAX_WAIT = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              disp_req,
  input  logic [frame_mem_pkg::ADDR_W-1:0]  disp_addr,
  output logic                              disp_gnt,
  output logic [frame_mem_pkg::DATA_W-1:0]  disp_rdata,
  output logic                              disp_rvalid,
  input  logic                              proc_req,
  input  logic                              proc_we,
  input  logic [frame_mem_pkg::ADDR_W-1:0]  proc_addr,
  input  logic [frame_mem_pkg::DATA_W-1:0]  proc_wdata,
  output logic                              proc_gnt,
  output logic [frame_mem_pkg::DATA_W-1:0]  proc_rdata,
  output logic                              proc_rvalid,
  output logic                              mem_en,
  output logic                              mem_we,
  output logic [frame_mem_pkg::ADDR_W-1:0]  mem_addr,
  output logic [frame_mem_pkg::DATA_W-1:0]  mem_wdata,
  input  logic [frame_mem_pkg::DATA_W-1:0]  mem_rdata,
  output logic [1:0]                        owner,
  output logic                              oob_err
);
  import frame_mem_pkg::*;
  localparam int LIMIT = FRAME_W * FRAME_H;
  owner_t state, state_nx;
  logic [2:0] wait_cnt;
  logic starve, gnt_any, gnt_oob;
  logic [ADDR_W-1:0] gnt_addr;
  tag_t tag_in, tag_out;
  assign starve = wait_cnt == 3'(MAX_WAIT);
  // grants are gated by rst so every output is quiet while reset is held
  always_comb begin
    disp_gnt = !rst && disp_req && !(proc_req && starve);
    proc_gnt = !rst && proc_req && !disp_gnt;
    gnt_any = disp_gnt || proc_gnt;
    gnt_addr = proc_gnt ? proc_addr : disp_addr;
    gnt_oob = gnt_any && out_of_range(gnt_addr, LIMIT);
    state_nx = disp_gnt ? DISP : proc_gnt ? PROC : IDLE;
    tag_in.valid = gnt_any && !(proc_gnt && proc_we);
    tag_in.owner = state_nx;
    tag_in.oob = gnt_oob;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      wait_cnt <= '0;
      oob_err <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_nx;
      wait_cnt <= (proc_req && !proc_gnt) ? (starve ? wait_cnt : wait_cnt + 3'd1) : '0;
      oob_err <= oob_err || gnt_oob;
      mem_en <= gnt_any && !gnt_oob;
      mem_we <= proc_gnt && proc_we && !gnt_oob;
      mem_addr <= gnt_any ? gnt_addr : '0;
      mem_wdata <= proc_gnt ? proc_wdata : '0;
    end
  assign owner = state;
  rd_tag_pipe u_tags (
    .clk(clk),
    .rst(rst),
    .tag_in(tag_in),
    .tag_out(tag_out)
  );
  // out-of-range reads still complete, but with zero data
  assign disp_rvalid = tag_out.valid && tag_out.owner == DISP;
  assign proc_rvalid = tag_out.valid && tag_out.owner == PROC;
  assign disp_rdata = (disp_rvalid && !tag_out.oob) ? mem_rdata : '0;
  assign proc_rdata = (proc_rvalid && !tag_out.oob) ? mem_rdata : '0;
endmodule

// File: tb/tb_frame_mem_arbiter.sv
// tb_frame_mem_arbiter: directed vectors plus hand-written multi-cycle sequences
module tb_frame_mem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic disp_req = 1'b0, proc_req = 1'b0, proc_we = 1'b0;
  logic [14:0] disp_addr = '0, proc_addr = '0;
  logic [23:0] proc_wdata = '0;
  logic disp_gnt, disp_rvalid, proc_gnt, proc_rvalid, mem_en, mem_we, oob_err;
  logic [23:0] disp_rdata, proc_rdata, mem_wdata;
  logic [23:0] mem_rdata = '0;
  logic [14:0] mem_addr;
  logic [1:0] owner;
  logic [23:0] ram [0:32767];
  int checks = 0, errors = 0;

  typedef struct {
    logic dreq, preq, dg, pg;
    logic [1:0] own;
  } vec_t;
  vec_t tv [15];

  frame_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
    .proc_req(proc_req), .proc_we(proc_we), .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_gnt(proc_gnt), .proc_rdata(proc_rdata), .proc_rvalid(proc_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner), .oob_err(oob_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic dr, input logic [14:0] da, input logic pr, input logic pw,
                       input logic [14:0] pa, input logic [23:0] pd);
    disp_req = dr; disp_addr = da; proc_req = pr; proc_we = pw; proc_addr = pa; proc_wdata = pd;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = '0;
    ram[0] = 24'h111111; ram[1] = 24'h222222; ram[2] = 24'h333333;
    tv[0]  = '{0, 0, 0, 0, 2'd0};
    tv[1]  = '{1, 0, 1, 0, 2'd0};
    tv[2]  = '{0, 1, 0, 1, 2'd1};
    tv[3]  = '{1, 1, 1, 0, 2'd2};
    tv[4]  = '{1, 1, 1, 0, 2'd1};
    tv[5]  = '{1, 1, 1, 0, 2'd1};
    tv[6]  = '{1, 1, 1, 0, 2'd1};
    tv[7]  = '{1, 1, 0, 1, 2'd1};
    tv[8]  = '{1, 1, 1, 0, 2'd2};
    tv[9]  = '{1, 1, 1, 0, 2'd1};
    tv[10] = '{1, 1, 1, 0, 2'd1};
    tv[11] = '{1, 1, 1, 0, 2'd1};
    tv[12] = '{1, 1, 0, 1, 2'd1};
    tv[13] = '{1, 1, 1, 0, 2'd2};
    tv[14] = '{1, 1, 1, 0, 2'd1};

    disp_req = 1'b1; proc_req = 1'b1;
    #3;
    chk("rst_disp_gnt", disp_gnt, 0);
    chk("rst_proc_gnt", proc_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_owner", owner, 0);
    chk("rst_oob_err", oob_err, 0);
    chk("rst_rvalid", {disp_rvalid, proc_rvalid}, 0);
    tick; rst = 1'b0; drive(0, 0, 0, 0, 0, 0);
    tick;

    for (int i = 0; i < 15; i++) begin
      tick;
      drive(tv[i].dreq, 15'd6, tv[i].preq, 0, 15'd5, 0);
      chk($sformatf("vec%0d_disp_gnt", i), disp_gnt, tv[i].dg);
      chk($sformatf("vec%0d_proc_gnt", i), proc_gnt, tv[i].pg);
      chk($sformatf("vec%0d_owner", i), owner, tv[i].own);
    end
    tick; drive(0, 0, 0, 0, 0, 0);
    tick; tick; tick;

    tick; drive(0, 0, 1, 1, 15'd100, 24'hABCDEF);
    chk("wr_proc_gnt", proc_gnt, 1);
    chk("wr_disp_gnt", disp_gnt, 0);
    tick; drive(0, 0, 1, 0, 15'd100, 0);
    chk("rd_proc_gnt", proc_gnt, 1);
    chk("wr_mem_en", mem_en, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 100);
    chk("wr_mem_wdata", mem_wdata, 24'hABCDEF);
    tick; drive(0, 0, 0, 0, 0, 0);
    chk("rd_mem_en", mem_en, 1);
    chk("rd_mem_we", mem_we, 0);
    chk("wr_no_rvalid", proc_rvalid, 0);
    tick;
    chk("rd_proc_rvalid", proc_rvalid, 1);
    chk("rd_proc_rdata", proc_rdata, 24'hABCDEF);
    chk("rd_disp_rvalid", disp_rvalid, 0);
    chk("idle_mem_en", mem_en, 0);
    tick;
    chk("rd_rvalid_drop", proc_rvalid, 0);
    chk("rd_rdata_zero", proc_rdata, 0);

    tick; drive(1, 15'd0, 0, 0, 0, 0);
    chk("alt0_disp_gnt", disp_gnt, 1);
    tick; drive(0, 0, 1, 0, 15'd1, 0);
    chk("alt1_proc_gnt", proc_gnt, 1);
    tick; drive(1, 15'd2, 0, 0, 0, 0);
    chk("alt2_disp_gnt", disp_gnt, 1);
    chk("alt0_disp_rvalid", disp_rvalid, 1);
    chk("alt0_disp_rdata", disp_rdata, 24'h111111);
    tick; drive(0, 0, 0, 0, 0, 0);
    chk("alt1_proc_rvalid", proc_rvalid, 1);
    chk("alt1_proc_rdata", proc_rdata, 24'h222222);
    chk("alt1_disp_rvalid", disp_rvalid, 0);
    tick;
    chk("alt2_disp_rvalid", disp_rvalid, 1);
    chk("alt2_disp_rdata", disp_rdata, 24'h333333);
    chk("alt2_proc_rvalid", proc_rvalid, 0);
    tick;
    chk("alt_drain", {disp_rvalid, proc_rvalid}, 0);

    tick; drive(0, 0, 1, 1, 15'd19200, 24'h555555);
    chk("oob_wr_gnt", proc_gnt, 1);
    chk("oob_pre_err", oob_err, 0);
    tick; drive(1, 15'd19200, 0, 0, 0, 0);
    chk("oob_rd_gnt", disp_gnt, 1);
    chk("oob_wr_mem_en", mem_en, 0);
    chk("oob_wr_mem_we", mem_we, 0);
    chk("oob_err_set", oob_err, 1);
    tick; drive(0, 0, 0, 0, 0, 0);
    chk("oob_rd_mem_en", mem_en, 0);
    chk("oob_wr_no_rvalid", disp_rvalid | proc_rvalid, 0);
    tick;
    chk("oob_rd_rvalid", disp_rvalid, 1);
    chk("oob_rd_rdata", disp_rdata, 0);
    tick;
    chk("oob_err_sticky", oob_err, 1);
    chk("oob_last_written", ram[19200 % 32768] == 24'h555555, 0);

    tick; drive(1, 15'd1, 0, 0, 0, 0);
    chk("rs_disp_gnt", disp_gnt, 1);
    tick; rst = 1'b1; #1;
    chk("rs_gnt_gated", disp_gnt, 0);
    chk("rs_mem_en", mem_en, 0);
    chk("rs_mem_addr", mem_addr, 0);
    chk("rs_owner", owner, 0);
    chk("rs_oob_clear", oob_err, 0);
    chk("rs_rvalid", disp_rvalid, 0);
    @(negedge clk); rst = 1'b0; disp_req = 1'b0;
    tick; drive(1, 15'd2, 0, 0, 0, 0);
    chk("rs_first_gnt", disp_gnt, 1);
    chk("rs_discard", disp_rvalid, 0);
    tick; drive(0, 0, 0, 0, 0, 0);
    chk("rs_discard2", disp_rvalid, 0);
    tick;
    chk("rs_new_rvalid", disp_rvalid, 1);
    chk("rs_new_rdata", disp_rdata, 24'h333333);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
